// File: rtl/ysyx_22041412_idu_pkg.sv
// Shared decode encodings for the IDU: opcodes, micro-op field types and the packed uop layout.
// Also holds the funct7 legality set and the ALU-mode selector used by the decoder.
package ysyx_22041412_idu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    localparam int REG_W = 5;
    localparam int ALU_W = 4;

    typedef enum logic [ALU_W-1:0] {
        ALU_UADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_e;

    typedef enum logic [1:0] {V1_REG = 2'd0, V1_PC, V1_ZERO} v1_e;
    typedef enum logic [1:0] {V2_REG = 2'd0, V2_IMM, V2_FOUR} v2_e;
    typedef enum logic [1:0] {MEM_IDLE = 2'd0, MEM_LOAD, MEM_STORE} mem_e;
    typedef enum logic [1:0] {JMP_IDLE = 2'd0, JMP_JAL, JMP_JALR, JMP_BRANCH} jmp_e;
    typedef enum logic [2:0] {FMT_R = 3'd0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        alu_e             alu_mode;
        v1_e              v1type;
        v2_e              v2type;
        mem_e             mem_mode;
        jmp_e             jump_mode;
        logic [2:0]       func3;
        logic             mul_en;
        logic             div_en;
        logic             rv64_en;
        logic             fence_i;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

    function automatic logic funct7_ok(input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MDU);
    endfunction

    // instr[30] picks SUB over ADD (register form only) and SRA over SRL (both forms)
    function automatic alu_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_imm);
        alu_e m;
        case (f3)
            3'b000:  m = (alt && !is_imm) ? ALU_SUB : ALU_UADD;
            3'b001:  m = ALU_SLL;
            3'b010:  m = ALU_SLT;
            3'b011:  m = ALU_SLTU;
            3'b100:  m = ALU_XOR;
            3'b101:  m = alt ? ALU_SRA : ALU_SRL;
            3'b110:  m = ALU_OR;
            default: m = ALU_AND;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22041412_dec_core.sv
// Combinational RV32I/RV64I(+M) decoder: raw instruction -> packed uop, immediate, illegal flag.
// Illegal instructions produce an all-zero uop and immediate.
module ysyx_22041412_dec_core
    import ysyx_22041412_idu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int EN_MDU = 1
) (
    input  logic [31:0]      instr,
    output logic [UOP_W-1:0] uop,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    output logic             is_jal
);

    logic [6:0]         opcode;
    logic [6:0]         f7;
    uop_t               u;
    fmt_e               fmt;
    logic               bad;
    logic signed [31:0] imm32;

    always_comb begin
        opcode  = instr[6:0];
        f7      = instr[31:25];
        u       = '0;
        u.rs1   = instr[19:15];
        u.rs2   = instr[24:20];
        u.rd    = instr[11:7];
        u.func3 = instr[14:12];
        fmt     = FMT_R;
        bad     = 1'b0;
        imm32   = '0;

        case (opcode)
            OP_LUI:    begin fmt = FMT_U; u.v1type = V1_ZERO; u.v2type = V2_IMM; end
            OP_AUIPC:  begin fmt = FMT_U; u.v1type = V1_PC;   u.v2type = V2_IMM; end
            OP_JAL:    begin fmt = FMT_J; u.v1type = V1_PC; u.v2type = V2_FOUR; u.jump_mode = JMP_JAL;  end
            OP_JALR:   begin fmt = FMT_I; u.v1type = V1_PC; u.v2type = V2_FOUR; u.jump_mode = JMP_JALR; end
            OP_BRANCH: begin fmt = FMT_B; u.alu_mode = ALU_SUB; u.jump_mode = JMP_BRANCH; end
            OP_LOAD:   begin fmt = FMT_I; u.v2type = V2_IMM; u.mem_mode = MEM_LOAD;  end
            OP_STORE:  begin fmt = FMT_S; u.v2type = V2_IMM; u.mem_mode = MEM_STORE; end
            OP_IMM, OP_IMM32: begin
                fmt        = FMT_I;
                u.v2type   = V2_IMM;
                u.alu_mode = alu_sel(instr[14:12], instr[30], 1'b1);
                u.rv64_en  = (opcode == OP_IMM32);
                if (opcode == OP_IMM32 && XLEN == 32) bad = 1'b1;
            end
            OP_REG, OP_REG32: begin
                fmt       = FMT_R;
                u.rv64_en = (opcode == OP_REG32);
                if (f7 == F7_MDU) begin
                    u.mul_en = !instr[14];
                    u.div_en = instr[14];
                    if (EN_MDU == 0) bad = 1'b1;
                end else begin
                    u.alu_mode = alu_sel(instr[14:12], instr[30], 1'b0);
                    if (!funct7_ok(f7)) bad = 1'b1;
                end
                if (opcode == OP_REG32 && XLEN == 32) bad = 1'b1;
            end
            OP_FENCE:  begin fmt = FMT_I; u.fence_i = (instr[14:12] == 3'b001); end
            OP_SYSTEM: fmt = FMT_I;
            default:   bad = 1'b1;
        endcase

        // J-type register fields overlap immediate bits, so they are cleared like U-type
        case (fmt)
            FMT_I:        u.rs2 = '0;
            FMT_S, FMT_B: u.rd  = '0;
            FMT_U, FMT_J: begin u.rs1 = '0; u.rs2 = '0; end
            default: ;
        endcase

        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        if (bad) begin
            u     = '0;
            imm32 = '0;
        end
    end

    assign uop     = u;
    assign imm     = XLEN'(imm32);
    assign illegal = bad;
    assign is_jal  = !bad && (opcode == OP_JAL);

endmodule

// File: rtl/ysyx_22041412_idu_stage.sv
// Instruction-decode stage: decoder feeding a DEPTH-entry FIFO with registered head outputs,
// plus an early JAL target pulse back to the IFU.
module ysyx_22041412_idu_stage
    import ysyx_22041412_idu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 2,
    parameter int EN_MDU = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [UOP_W-1:0] out_uop,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic             jal_valid,
    output logic [XLEN-1:0]  jal_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [UOP_W-1:0] uop_p0;
    logic [XLEN-1:0]  imm_p0;
    logic             illegal_p0;
    logic             is_jal_p0;

    logic [XLEN-1:0]  pc_mem  [DEPTH];
    logic [UOP_W-1:0] uop_mem [DEPTH];
    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic             ill_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    ysyx_22041412_dec_core #(
        .XLEN   (XLEN),
        .EN_MDU (EN_MDU)
    ) u_dec (
        .instr   (in_instr),
        .uop     (uop_p0),
        .imm     (imm_p0),
        .illegal (illegal_p0),
        .is_jal  (is_jal_p0)
    );

    assign in_ready  = (count != FULL_CNT) && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign rd_nxt    = rd_ptr + PTR_W'(1);

    // p0 -> FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= in_pc;
            uop_mem[wr_ptr] <= uop_p0;
            imm_mem[wr_ptr] <= imm_p0;
            ill_mem[wr_ptr] <= illegal_p0;
        end
    end

    // Head registers mirror the FIFO head and keep the last popped entry once empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_pc      <= '0;
            out_uop     <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            jal_valid   <= 1'b0;
            jal_pc      <= '0;
        end else begin
            jal_valid <= push && is_jal_p0;
            if (push && is_jal_p0) jal_pc <= in_pc + imm_p0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_nxt;
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end

            if (push && (count == '0 || (pop && count == CNT_W'(1)))) begin
                out_pc      <= in_pc;
                out_uop     <= uop_p0;
                out_imm     <= imm_p0;
                out_illegal <= illegal_p0;
            end else if (pop && count > CNT_W'(1)) begin
                out_pc      <= pc_mem[rd_nxt];
                out_uop     <= uop_mem[rd_nxt];
                out_imm     <= imm_mem[rd_nxt];
                out_illegal <= ill_mem[rd_nxt];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_idu_stage.sv
// Directed bench for the IDU stage: main RV64+M instance plus XLEN=32 and no-MDU instances.
module tb_ysyx_22041412_idu_stage;
    import ysyx_22041412_idu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             flush, in_valid, in_ready, out_valid, out_ready, out_illegal, jal_valid;
    logic [31:0]      in_instr;
    logic [63:0]      in_pc, out_pc, out_imm, jal_pc;
    logic [UOP_W-1:0] out_uop;

    logic             a_in_valid, a_in_ready, a_out_valid, a_out_illegal, a_jal_valid;
    logic [31:0]      a_in_instr, a_in_pc, a_out_pc, a_out_imm, a_jal_pc;
    logic [UOP_W-1:0] a_out_uop;

    logic             b_in_valid, b_in_ready, b_out_valid, b_out_illegal, b_jal_valid;
    logic [31:0]      b_in_instr;
    logic [63:0]      b_in_pc, b_out_pc, b_out_imm, b_jal_pc;
    logic [UOP_W-1:0] b_out_uop;

    uop_t u, ua;
    assign u  = uop_t'(out_uop);
    assign ua = uop_t'(a_out_uop);

    int n_vec = 0;
    int n_err = 0;

    ysyx_22041412_idu_stage #(.XLEN(64), .DEPTH(2), .EN_MDU(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_uop(out_uop), .out_imm(out_imm), .out_illegal(out_illegal),
        .jal_valid(jal_valid), .jal_pc(jal_pc)
    );

    ysyx_22041412_idu_stage #(.XLEN(32), .DEPTH(2), .EN_MDU(1)) dut32 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_pc(a_in_pc), .out_valid(a_out_valid), .out_ready(1'b1),
        .out_pc(a_out_pc), .out_uop(a_out_uop), .out_imm(a_out_imm), .out_illegal(a_out_illegal),
        .jal_valid(a_jal_valid), .jal_pc(a_jal_pc)
    );

    ysyx_22041412_idu_stage #(.XLEN(64), .DEPTH(2), .EN_MDU(0)) dutnm (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_pc(b_out_pc), .out_uop(b_out_uop), .out_imm(b_out_imm), .out_illegal(b_out_illegal),
        .jal_valid(b_jal_valid), .jal_pc(b_jal_pc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
        in_instr = ins;
        in_pc    = pc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        flush = 0; in_valid = 0; out_ready = 1; in_instr = '0; in_pc = '0;
        a_in_valid = 0; a_in_instr = '0; a_in_pc = '0;
        b_in_valid = 0; b_in_instr = '0; b_in_pc = '0;
        #1 rst = 1'b1;
        tick(); tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_jal_valid", jal_valid, 0);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_out_uop", out_uop, 0);
        check_eq("rst_jal_pc", jal_pc, 0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", in_ready, 1);

        // illegal detection on the XLEN=32 and no-MDU instances
        a_in_instr = 32'h0010009B; a_in_pc = 32'h1000; a_in_valid = 1;
        b_in_instr = 32'h02208033; b_in_pc = 64'h2000; b_in_valid = 1;
        tick();
        check_eq("x32_addiw_valid", a_out_valid, 1);
        check_eq("x32_addiw_illegal", a_out_illegal, 1);
        check_eq("x32_addiw_rd", ua.rd, 0);
        check_eq("x32_addiw_uop", a_out_uop, 0);
        check_eq("nomdu_mul_illegal", b_out_illegal, 1);
        check_eq("nomdu_mul_uop", b_out_uop, 0);
        a_in_instr = 32'h00510093; a_in_pc = 32'h1004;
        b_in_instr = 32'h007302B3; b_in_pc = 64'h2004;
        tick();
        check_eq("x32_addi_illegal", a_out_illegal, 0);
        check_eq("x32_addi_imm", a_out_imm, 5);
        check_eq("nomdu_add_illegal", b_out_illegal, 0);
        a_in_valid = 0; b_in_valid = 0;
        tick();

        // addi x1,x2,5
        issue(32'h00510093, 64'h80000000);
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_pc", out_pc, 64'h80000000);
        check_eq("addi_rs1", u.rs1, 2);
        check_eq("addi_rs2", u.rs2, 0);
        check_eq("addi_rd", u.rd, 1);
        check_eq("addi_imm", out_imm, 5);
        check_eq("addi_alu", u.alu_mode, ALU_UADD);
        check_eq("addi_illegal", out_illegal, 0);
        tick();
        check_eq("drain_valid", out_valid, 0);
        check_eq("drain_hold_pc", out_pc, 64'h80000000);

        // jal x1,+16
        issue(32'h010000EF, 64'h80000010);
        check_eq("jal_pulse", jal_valid, 1);
        check_eq("jal_pc", jal_pc, 64'h80000020);
        check_eq("jal_imm", out_imm, 16);
        check_eq("jal_mode", u.jump_mode, JMP_JAL);
        tick();
        check_eq("jal_pulse_end", jal_valid, 0);
        check_eq("jal_pc_hold", jal_pc, 64'h80000020);

        // immediate formats and register forcing
        issue(32'h800000B7, 64'h100);
        check_eq("lui_imm", out_imm, 64'hFFFFFFFF80000000);
        check_eq("lui_rs1", u.rs1, 0);
        check_eq("lui_v1", u.v1type, V1_ZERO);
        issue(32'hFE512E23, 64'h104);
        check_eq("sw_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        check_eq("sw_rd", u.rd, 0);
        check_eq("sw_rs2", u.rs2, 5);
        check_eq("sw_mem", u.mem_mode, MEM_STORE);
        issue(32'hFE208CE3, 64'h108);
        check_eq("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFF8);
        check_eq("beq_rd", u.rd, 0);
        check_eq("beq_jump", u.jump_mode, JMP_BRANCH);
        issue(32'h0000007F, 64'h10C);
        check_eq("badop_illegal", out_illegal, 1);
        check_eq("badop_uop", out_uop, 0);
        check_eq("badop_valid", out_valid, 1);
        issue(32'h04208033, 64'h110);
        check_eq("badf7_illegal", out_illegal, 1);
        issue(32'h02208033, 64'h114);
        check_eq("mul_illegal", out_illegal, 0);
        check_eq("mul_en", u.mul_en, 1);
        tick();

        // backpressure: fill, hold, drain in order
        out_ready = 0;
        in_valid = 1; in_instr = 32'h00100193; in_pc = 64'h200;
        tick();
        check_eq("bp_ready1", in_ready, 1);
        check_eq("bp_head_a", out_pc, 64'h200);
        in_instr = 32'h007302B3; in_pc = 64'h204;
        tick();
        check_eq("bp_full", in_ready, 0);
        check_eq("bp_head_a2", out_pc, 64'h200);
        in_instr = 32'h40A48433; in_pc = 64'h208;
        tick();
        check_eq("bp_head_a3", out_pc, 64'h200);
        check_eq("bp_head_rd", u.rd, 3);
        check_eq("bp_still_full", in_ready, 0);
        out_ready = 1;
        tick();
        check_eq("bp_head_b", out_pc, 64'h204);
        check_eq("bp_b_rs2", u.rs2, 7);
        tick();
        check_eq("bp_head_c", out_pc, 64'h208);
        check_eq("bp_c_alu", u.alu_mode, ALU_SUB);
        in_valid = 0;
        tick();
        check_eq("bp_empty", out_valid, 0);

        // flush with two buffered entries and a JAL on the input
        out_ready = 0;
        issue(32'h00100193, 64'h300);
        issue(32'h007302B3, 64'h304);
        check_eq("fl_full", in_ready, 0);
        flush = 1; in_valid = 1; in_instr = 32'h010000EF; in_pc = 64'h400;
        tick();
        check_eq("fl_valid", out_valid, 0);
        check_eq("fl_ready", in_ready, 1);
        check_eq("fl_no_jal", jal_valid, 0);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        check_eq("fl_nothing", out_valid, 0);
        check_eq("fl_jal_pc", jal_pc, 64'h80000020);

        // asynchronous reset mid-operation
        out_ready = 0;
        issue(32'h010000EF, 64'h500);
        check_eq("mr_jal", jal_valid, 1);
        check_eq("mr_jal_pc", jal_pc, 64'h510);
        #1 rst = 1'b1;
        #1;
        check_eq("mr_out_valid", out_valid, 0);
        check_eq("mr_jal_valid", jal_valid, 0);
        check_eq("mr_in_ready", in_ready, 0);
        check_eq("mr_jal_pc0", jal_pc, 0);
        #1 rst = 1'b0;
        out_ready = 1;
        issue(32'h00510093, 64'h600);
        check_eq("mr_after_valid", out_valid, 1);
        check_eq("mr_after_pc", out_pc, 64'h600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
